// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the write-port arbiter and its neighbours.
package regfile_pkg;

    localparam int RF_ADDR_W = 2;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 4;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    always_comb begin
        int cand;
        cand        = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with optional multi-beat lock in front of the register file
// write port; the winning beat is registered and presented one cycle later.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int DATA_W       = RF_DATA_W,
    parameter int LOCK_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_write_enable,
    output logic [ADDR_W-1:0]             rf_write_register,
    output logic [DATA_W-1:0]             rf_write_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    arb_state_e         state_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    lock_owner_q;
    logic [CNT_W-1:0]   idle_cnt_q;

    logic [NUM_REQ-1:0] rr_grant;
    logic [ID_W-1:0]    rr_idx;
    logic               rr_any;

    logic               owner_valid;
    logic               xfer;
    logic [ID_W-1:0]    xfer_id;
    logic               xfer_lock;
    logic [ADDR_W-1:0]  xfer_addr;
    logic [DATA_W-1:0]  xfer_data;

    logic               vld_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [DATA_W-1:0]  data_p1;
    logic [ID_W-1:0]    id_p1;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant       (rr_grant),
        .grant_idx   (rr_idx),
        .grant_valid (rr_any)
    );

    assign owner_valid = req_valid[lock_owner_q];

    // Stage p0: pick the beat accepted this cycle; nothing is accepted while in reset.
    always_comb begin
        xfer      = 1'b0;
        xfer_id   = rr_idx;
        req_ready = '0;
        if (rst_n) begin
            if (state_q == ARB_FREE) begin
                xfer      = rr_any;
                xfer_id   = rr_idx;
                req_ready = rr_grant;
            end else begin
                xfer      = owner_valid;
                xfer_id   = lock_owner_q;
                req_ready = owner_valid ? (NUM_REQ'(1) << lock_owner_q) : '0;
            end
        end
    end

    assign xfer_lock = req_lock[xfer_id];
    assign xfer_addr = req_addr[int'(xfer_id)*ADDR_W +: ADDR_W];
    assign xfer_data = req_data[int'(xfer_id)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_FREE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            lock_owner_q <= '0;
            idle_cnt_q   <= '0;
        end else begin
            case (state_q)
                ARB_FREE: begin
                    if (xfer) begin
                        last_grant_q <= xfer_id;
                        if (xfer_lock) begin
                            state_q      <= ARB_LOCKED;
                            lock_owner_q <= xfer_id;
                            idle_cnt_q   <= '0;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (xfer) begin
                        idle_cnt_q   <= '0;
                        last_grant_q <= xfer_id;
                        if (!xfer_lock) state_q <= ARB_FREE;
                    end else if (LOCK_TIMEOUT != 0) begin
                        // Owner went quiet: release without moving the pointer.
                        if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            state_q    <= ARB_FREE;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ARB_FREE;
            endcase
        end
    end

    // Stage p1: registered write port; reset drops any captured beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            id_p1   <= '0;
        end else begin
            vld_p1 <= xfer;
            if (xfer) begin
                addr_p1 <= xfer_addr;
                data_p1 <= xfer_data;
                id_p1   <= xfer_id;
            end
        end
    end

    assign rf_write_enable   = vld_p1;
    assign rf_write_register = addr_p1;
    assign rf_write_data     = data_p1;
    assign grant_id          = id_p1;
    assign busy              = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_lock;
    logic [5:0]  req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_write_enable;
    logic [1:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic [1:0]  grant_id;
    logic        busy;

    regfile_write_arbiter #(
        .NUM_REQ      (N),
        .ADDR_W       (2),
        .DATA_W       (32),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_lock          (req_lock),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .rf_write_enable   (rf_write_enable),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .grant_id          (grant_id),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model
    bit          chk_on = 1'b0;
    bit          m_locked;
    int          m_owner;
    int          m_last;
    int          m_idle;
    logic        exp_en;
    logic [1:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_id;
    logic [31:0] ref_rf [4];
    logic [31:0] dut_rf [4];

    function automatic logic [2:0] model_ready();
        logic [2:0] one;
        one = 3'b001;
        if (rst_n !== 1'b1) return 3'b000;
        if (m_locked) return req_valid[m_owner] ? (one << m_owner) : 3'b000;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (req_valid[c]) return one << c;
        end
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = N - 1;
        m_idle   = 0;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_id   = '0;
    endtask

    initial begin
        model_reset();
        for (int r = 0; r < 4; r++) begin
            ref_rf[r] = '0;
            dut_rf[r] = '0;
        end
    end

    always @(posedge clk) begin
        logic [2:0] rdy;
        int w;
        if (exp_en) ref_rf[exp_addr] = exp_data;
        if (rf_write_enable === 1'b1) dut_rf[rf_write_register] = rf_write_data;
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            rdy = model_ready();
            if (rdy != 3'b000) begin
                w = rdy[0] ? 0 : (rdy[1] ? 1 : 2);
                exp_en   = 1'b1;
                exp_addr = req_addr[w*2 +: 2];
                exp_data = req_data[w*32 +: 32];
                exp_id   = 2'(w);
                m_last   = w;
                if (m_locked) begin
                    m_idle = 0;
                    if (!req_lock[w]) m_locked = 1'b0;
                end else if (req_lock[w]) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_idle   = 0;
                end
            end else begin
                exp_en = 1'b0;
                if (m_locked) begin
                    m_idle++;
                    if (m_idle == TO) begin
                        m_locked = 1'b0;
                        m_idle   = 0;
                    end
                end
            end
        end
        chk_on = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("req_ready", 64'(req_ready), 64'(model_ready()));
            chk("rf_we", 64'(rf_write_enable), 64'(exp_en));
            chk("rf_reg", 64'(rf_write_register), 64'(exp_addr));
            chk("rf_data", 64'(rf_write_data), 64'(exp_data));
            chk("grant_id", 64'(grant_id), 64'(exp_id));
            chk("busy", 64'(busy), 64'(m_locked));
            for (int r = 0; r < 4; r++) chk("rf_contents", 64'(dut_rf[r]), 64'(ref_rf[r]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int pct;
        logic [2:0] acc;

        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_lock  = 3'b000;
        req_addr  = {2'd3, 2'd2, 2'd1};
        req_data  = {32'hC, 32'hB, 32'hA};

        // Reset held with all requesters valid
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'h0);
            chk("rst_we", 64'(rf_write_enable), 64'h0);
        end
        tick();
        rst_n = 1'b1;

        // Continuous round-robin, first grant to requester 0
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
            if (k > 0) begin
                chk("rr_we", 64'(rf_write_enable), 64'h1);
                chk("rr_gid", 64'(grant_id), 64'((k - 1) % 3));
                chk("rr_data", 64'(rf_write_data), 64'(32'hA + (k - 1) % 3));
            end
            tick();
        end

        // Lock by requester 1: three locked beats then an unlocked beat
        req_valid = 3'b001;
        tick();
        req_valid = 3'b111;
        for (int b = 0; b < 4; b++) begin
            req_lock = (b < 3) ? 3'b010 : 3'b000;
            req_data[63:32] = 32'h100 + b;
            @(negedge clk);
            chk("lock_ready", 64'(req_ready), 64'h2);
            chk("lock_busy", 64'(busy), 64'(b > 0));
            tick();
        end
        req_lock = 3'b000;
        @(negedge clk);
        chk("unlock_ready", 64'(req_ready), 64'h4);
        chk("unlock_busy", 64'(busy), 64'h0);
        tick();

        // Lock then owner idles for the full timeout
        req_valid = 3'b001;
        tick();
        req_valid = 3'b010;
        req_lock  = 3'b010;
        tick();
        req_valid = 3'b101;
        req_lock  = 3'b000;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            chk("to_busy", 64'(busy), 64'h1);
            chk("to_ready", 64'(req_ready), 64'h0);
            tick();
        end
        @(negedge clk);
        chk("to_released", 64'(busy), 64'h0);
        chk("to_next_ready", 64'(req_ready), 64'h4);
        tick();

        // Owner idles one cycle short of the timeout and keeps the lock
        req_valid = 3'b001;
        tick();
        req_valid = 3'b010;
        req_lock  = 3'b010;
        tick();
        req_valid = 3'b101;
        req_lock  = 3'b000;
        repeat (TO - 1) tick();
        req_valid = 3'b111;
        @(negedge clk);
        chk("short_idle_busy", 64'(busy), 64'h1);
        chk("short_idle_ready", 64'(req_ready), 64'h2);
        tick();

        // Reset while locked with a beat in the output stage
        req_valid = 3'b100;
        req_lock  = 3'b100;
        tick();
        req_data[95:64] = 32'h5555;
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'h1);
        tick();
        rst_n     = 1'b0;
        req_valid = 3'b111;
        @(negedge clk);
        chk("in_rst_ready", 64'(req_ready), 64'h0);
        tick();
        rst_n    = 1'b1;
        req_lock = 3'b000;
        @(negedge clk);
        chk("post_rst_we", 64'(rf_write_enable), 64'h0);
        chk("post_rst_busy", 64'(busy), 64'h0);
        chk("post_rst_ready", 64'(req_ready), 64'h1);
        chk("post_rst_data", 64'(rf_write_data), 64'h0);
        tick();

        // Single requester writes reg 3
        req_valid       = 3'b100;
        req_addr[5:4]   = 2'd3;
        req_data[95:64] = 32'hDEADBEEF;
        @(negedge clk);
        chk("solo_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 3'b000;
        @(negedge clk);
        chk("solo_we", 64'(rf_write_enable), 64'h1);
        chk("solo_reg", 64'(rf_write_register), 64'h3);
        chk("solo_data", 64'(rf_write_data), 64'hDEADBEEF);
        chk("solo_gid", 64'(grant_id), 64'h2);
        tick();
        @(negedge clk);
        chk("solo_rf3", 64'(dut_rf[3]), 64'hDEADBEEF);

        // Back-to-back writes to the same register
        req_valid     = 3'b001;
        req_addr[1:0] = 2'd1;
        req_data[31:0] = 32'h11;
        tick();
        req_data[31:0] = 32'h22;
        @(negedge clk);
        chk("b2b_first", 64'(rf_write_data), 64'h11);
        tick();
        req_valid = 3'b000;
        @(negedge clk);
        chk("b2b_second", 64'(rf_write_data), 64'h22);
        chk("b2b_we", 64'(rf_write_enable), 64'h1);
        tick();
        @(negedge clk);
        chk("b2b_rf1", 64'(dut_rf[1]), 64'h22);

        // Randomized traffic; requesters hold their beat until accepted
        pct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) begin
                case ($urandom_range(2))
                    0:       pct = 10;
                    1:       pct = 50;
                    default: pct = 90;
                endcase
            end
            @(negedge clk);
            acc = req_ready & req_valid;
            tick();
            rst_n = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom_range(99) < pct)) begin
                    req_valid[i]         = 1'b1;
                    req_addr[i*2 +: 2]   = 2'($urandom_range(3));
                    req_data[i*32 +: 32] = $urandom;
                    req_lock[i]          = ($urandom_range(2) == 0);
                end
            end
        end
        rst_n = 1'b1;
        req_valid = 3'b000;
        tick();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
